// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: geometry, width helpers and the miss FSM
// state encoding. The LRU block and the tag-compare stage import this too.
`timescale 1ns/1ps

package dcache_pkg;

  // Default cache geometry
  localparam int DCACHE_WAYS       = 4;
  localparam int DCACHE_CACHE_SIZE = 32768;
  localparam int DCACHE_BLOCK_SIZE = 16;
  localparam int DCACHE_ADDR_W     = 32;
  localparam int DCACHE_DATA_W     = 32;

  // Byte-offset bits inside one line
  function automatic int offset_bits(input int block_size);
    return $clog2(block_size);
  endfunction

  // Set-index bits for a given size, line size and associativity
  function automatic int index_bits(input int cache_size, input int block_size, input int ways);
    return $clog2(cache_size / (block_size * ways));
  endfunction

  // Derived widths for the default geometry (4 / 9 / 19 / 4 words)
  localparam int DCACHE_OFFSET_W = offset_bits(DCACHE_BLOCK_SIZE);
  localparam int DCACHE_INDEX_W  = index_bits(DCACHE_CACHE_SIZE, DCACHE_BLOCK_SIZE, DCACHE_WAYS);
  localparam int DCACHE_TAG_W    = DCACHE_ADDR_W - DCACHE_INDEX_W - DCACHE_OFFSET_W;
  localparam int DCACHE_WORDS    = DCACHE_BLOCK_SIZE / (DCACHE_DATA_W / 8);

  // Miss-handling FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } miss_state_e;

endpackage

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: on a lookup miss it writes back a dirty victim
// line word by word, then refills the line from memory one word per read,
// and finally signals the array to install the new tag.
`timescale 1ns/1ps

import dcache_pkg::*;

module dcache_miss_ctrl #(
  parameter int WAYS       = DCACHE_WAYS,
  parameter int CACHE_SIZE = DCACHE_CACHE_SIZE,
  parameter int BLOCK_SIZE = DCACHE_BLOCK_SIZE,
  parameter int ADDR_W     = DCACHE_ADDR_W,
  parameter int DATA_W     = DCACHE_DATA_W,
  localparam int OFFSET_W  = offset_bits(BLOCK_SIZE),
  localparam int INDEX_W   = index_bits(CACHE_SIZE, BLOCK_SIZE, WAYS),
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W,
  localparam int WORDS     = BLOCK_SIZE / (DATA_W / 8)
) (
  input  logic              clock,
  input  logic              rst,
  // Lookup stage
  input  logic              lookup_valid_i,
  input  logic              hit_i,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        lru_select_i,
  input  logic              victim_dirty_i,
  input  logic [TAG_W-1:0]  victim_tag_i,
  // Array read port (victim data for write-back)
  output logic [1:0]        line_rd_word_o,
  input  logic [DATA_W-1:0] line_rd_data_i,
  // Memory interface
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  // Array refill port
  output logic              refill_we_o,
  output logic [1:0]        refill_way_o,
  output logic [INDEX_W-1:0] refill_index_o,
  output logic [1:0]        refill_word_o,
  output logic [DATA_W-1:0] refill_data_o,
  output logic              refill_done_o,
  output logic [TAG_W-1:0]  refill_tag_o,
  // Pipeline control
  output logic              stall_o,
  output logic              err_o
);

  // Word index is 2 bits wide; the remaining offset bits select bytes
  localparam int                  BYTE_W    = OFFSET_W - 2;
  localparam logic [BYTE_W-1:0]   BYTE_PAD  = '0;
  localparam logic [1:0]          LAST_WORD = 2'(WORDS - 1);

  miss_state_e        state_q, state_d;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   vtag_q;
  logic [INDEX_W-1:0] index_q;
  logic [1:0]         way_q;
  logic [1:0]         word_q, word_d;
  logic               err_q, err_d;
  logic               load;

  // Address split into tag / set index; byte offset is not needed
  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] addr_index;
  logic               unused_offset;

  assign addr_tag      = addr_i[ADDR_W-1 -: TAG_W];
  assign addr_index    = addr_i[OFFSET_W +: INDEX_W];
  assign unused_offset = ^addr_i[OFFSET_W-1:0];

  // A lookup is only acted upon out of reset, so every output stays 0 while rst is low
  logic lookup_ok;
  assign lookup_ok = rst && lookup_valid_i;

  assign err_o = err_q;

  // State register
  always_ff @(posedge clock or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched miss context, word counter and the error pulse
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      tag_q   <= '0;
      vtag_q  <= '0;
      index_q <= '0;
      way_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (load) begin
        tag_q   <= addr_tag;
        vtag_q  <= victim_tag_i;
        index_q <= addr_index;
        way_q   <= lru_select_i;
      end
      word_q <= word_d;
      err_q  <= err_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d        = state_q;
    word_d         = word_q;
    load           = 1'b0;
    err_d          = 1'b0;
    stall_o        = 1'b0;
    line_rd_word_o = '0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    refill_we_o    = 1'b0;
    refill_way_o   = '0;
    refill_index_o = '0;
    refill_word_o  = '0;
    refill_data_o  = '0;
    refill_done_o  = 1'b0;
    refill_tag_o   = '0;

    unique case (state_q)
      IDLE: begin
        if (lookup_ok && hit_i && miss_i) begin
          // Contradictory lookup result: flag it, start nothing
          err_d = 1'b1;
        end else if (lookup_ok && miss_i) begin
          load    = 1'b1;
          word_d  = '0;
          stall_o = 1'b1;
          state_d = victim_dirty_i ? WB : RD_REQ;
        end
      end

      WB: begin
        stall_o        = 1'b1;
        mem_req_o      = 1'b1;
        mem_we_o       = 1'b1;
        mem_addr_o     = {vtag_q, index_q, word_q, BYTE_PAD};
        line_rd_word_o = word_q;
        mem_wdata_o    = line_rd_data_i;
        if (mem_gnt_i) begin
          word_d = word_q + 2'd1;
          if (word_q == LAST_WORD) begin
            state_d = RD_REQ;
          end
        end
      end

      RD_REQ: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {tag_q, index_q, word_q, BYTE_PAD};
        if (mem_gnt_i) begin
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          refill_we_o    = 1'b1;
          refill_way_o   = way_q;
          refill_index_o = index_q;
          refill_word_o  = word_q;
          refill_data_o  = mem_rdata_i;
          word_d         = word_q + 2'd1;
          state_d        = (word_q == LAST_WORD) ? DONE : RD_REQ;
        end
      end

      DONE: begin
        stall_o        = 1'b1;
        refill_done_o  = 1'b1;
        refill_tag_o   = tag_q;
        refill_way_o   = way_q;
        refill_index_o = index_q;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/dcache_miss_ctrl.md
DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- WAYS, 4, associativity.
- CACHE_SIZE, 32768, bytes.
- BLOCK_SIZE, 16, bytes per line.
- ADDR_W, 32, address bits.
- DATA_W, 32, word bits.
- Derived values: OFFSET_W=4, INDEX_W=9, TAG_W=19, WORDS=4.

REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clock, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- lookup_valid_i, in, 1, tag-compare result valid this cycle.
- hit_i, in, 1, lookup hit.
- miss_i, in, 1, lookup miss.
- addr_i, in, ADDR_W, lookup address.
- lru_select_i, in, 2, victim way from the LRU block.
- victim_dirty_i, in, 1, selected victim line is dirty.
- victim_tag_i, in, TAG_W, selected victim tag.
- line_rd_word_o, out, 2, word index driven to the array read port.
- line_rd_data_i, in, DATA_W, combinational array read data for (latched way, index, line_rd_word_o).
- mem_req_o, out, 1, memory request.
- mem_we_o, out, 1, memory write.
- mem_addr_o, out, ADDR_W, word-aligned memory address.
- mem_wdata_o, out, DATA_W, memory write data.
- mem_gnt_i, in, 1, request accepted.
- mem_rvalid_i, in, 1, read data valid.
- mem_rdata_i, in, DATA_W, read data.
- refill_we_o, out, 1, write one word into the array.
- refill_way_o, out, 2, array way.
- refill_index_o, out, INDEX_W, array set.
- refill_word_o, out, 2, array word.
- refill_data_o, out, DATA_W, array data.
- refill_done_o, out, 1, one-cycle pulse: write refill_tag_o, set valid, clear dirty.
- refill_tag_o, out, TAG_W, new tag.
- stall_o, out, 1, pipeline stall.
- err_o, out, 1, one-cycle pulse on illegal hit_i and miss_i together.

Function
REQ-003 The block SHALL implement FSM states IDLE, WB, RD_REQ, RD_WAIT and DONE.
REQ-004 In IDLE, when lookup_valid_i and miss_i and !hit_i are all true, the block SHALL latch tag, index, lru_select_i, victim_dirty_i and victim_tag_i, clear the 2-bit word counter, and go to WB if the victim is dirty, otherwise to RD_REQ.
REQ-005 In IDLE, when lookup_valid_i, hit_i and miss_i are all true, the block SHALL pulse err_o the next cycle and start no miss; a hit alone SHALL cause no action.
REQ-006 stall_o SHALL be asserted combinationally in the accepting miss cycle and in every non-IDLE state, and deasserted when the FSM returns to IDLE.
REQ-007 In WB, the block SHALL drive mem_req_o=1, mem_we_o=1, mem_addr_o={victim_tag, index, word, 2'b00} and mem_wdata_o=line_rd_data_i, with line_rd_word_o=word.
REQ-008 In WB, the word counter SHALL advance on mem_gnt_i; on the grant of word 3 the counter SHALL wrap to 0 and the FSM SHALL go to RD_REQ.
REQ-009 In RD_REQ, the block SHALL drive mem_req_o=1, mem_we_o=0 and mem_addr_o={tag, index, word, 2'b00}; on mem_gnt_i the FSM SHALL go to RD_WAIT.
REQ-010 Only one read SHALL be outstanding at a time.
REQ-011 In RD_WAIT, on mem_rvalid_i the block SHALL assert refill_we_o in that same cycle with refill_way_o=latched way, refill_index_o=index, refill_word_o=word and refill_data_o=mem_rdata_i.
REQ-012 In RD_WAIT, after the rvalid of REQ-011 the word counter SHALL increment; the FSM SHALL go to DONE after word 3, otherwise back to RD_REQ.
REQ-013 DONE SHALL last exactly one cycle, asserting refill_done_o with refill_tag_o=tag and refill_way_o/refill_index_o held, then go to IDLE.
REQ-014 mem_req_o SHALL be held with stable address and data until mem_gnt_i.
REQ-015 mem_rvalid_i outside RD_WAIT SHALL be ignored.
REQ-016 lookup_valid_i outside IDLE SHALL be ignored; upstream holds the lookup while stall_o is asserted.
REQ-017 With mem_gnt_i constantly 1 and rvalid one cycle after grant:
- a clean miss SHALL spend 8 cycles in RD_REQ/RD_WAIT and hit DONE 9 cycles after acceptance;
- a dirty miss SHALL add 4 WB cycles.
REQ-018 All outputs not named active in a state SHALL be 0.

Reset
REQ-019 On rst low, asynchronously, the FSM SHALL enter IDLE, clear the counter and all latched fields, and drive every output to 0 (stall_o=0, err_o=0).
REQ-020 Reset asserted mid-miss SHALL abandon the transaction; any late mem_rvalid_i after reset SHALL be dropped.
REQ-021 No partial refill_done_o SHALL be issued after a reset.

Structure
REQ-022 Parameters, derived widths and the FSM state enum SHALL live in shared package dcache_pkg, also used by Cache_LRU and the tag-compare stage.
REQ-023 The block SHALL be a single module with no sub-module; the address split SHALL be done with package constants.

Verification
REQ-024 Clean miss: addr_i=0xabc12400, lru_select_i=2, victim clean, gnt=1, rvalid after 1 cycle -> reads at 0xabc12400/404/408/40C; refill_we_o four times with way 2 and index 0x040; refill_done_o with tag 0x55E09; stall_o released the next cycle.
REQ-025 Dirty miss: same address, lru_select_i=1, victim_tag_i=0x12345 -> four writes at 0x2468A400..40C carrying array words 0..3, then four reads as in REQ-024, refill way 1.
REQ-026 Grant backpressure: mem_gnt_i low for 3 cycles on word 2 -> address and data held stable, no counter advance, order preserved.
REQ-027 hit_i=1 and miss_i=1 together in IDLE -> err_o pulses, no mem_req_o, stall_o stays 0; spurious mem_rvalid_i in IDLE -> no refill_we_o.
REQ-028 rst low during RD_WAIT of word 1 -> all outputs 0 immediately; rvalid arriving after rst high -> ignored; a fresh miss then completes normally.
